lcd_byte_writer: RTL and testbench

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

---
 rtl/lcd_pkg.sv | 57 +++++
 rtl/lcd_nibble_strobe.sv | 82 ++++++++
 rtl/lcd_byte_writer.sv | 249 ++++++++++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD byte writer.
// Holds the FSM state encoding, the nibble strobe phase encoding,
// the default timing constants and small decode helpers.
package lcd_pkg;

    // Top-level sequencer states
    typedef enum logic [3:0] {
        ST_PWRUP     = 4'd0,
        ST_INIT_NIB  = 4'd1,
        ST_INIT_GAP  = 4'd2,
        ST_IDLE      = 4'd3,
        ST_HI_SETUP  = 4'd4,
        ST_HI_EN     = 4'd5,
        ST_HI_HOLD   = 4'd6,
        ST_NIB_GAP   = 4'd7,
        ST_LO_SETUP  = 4'd8,
        ST_LO_EN     = 4'd9,
        ST_LO_HOLD   = 4'd10,
        ST_BYTE_GAP  = 4'd11
    } lcd_state_e;

    // Phases of a single E strobe
    typedef enum logic [1:0] {
        PH_OFF   = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } strobe_phase_e;

    // Default timing in clock cycles (50 MHz board values)
    localparam int DEF_CYC_SETUP   = 2;
    localparam int DEF_CYC_EN      = 12;
    localparam int DEF_CYC_HOLD    = 1;
    localparam int DEF_CYC_NIB_GAP = 50;
    localparam int DEF_CYC_CMD_GAP = 2000;
    localparam int DEF_CYC_CLR_GAP = 82000;
    localparam int DEF_CYC_PWRUP   = 750000;
    localparam int DEF_CYC_INIT1   = 205000;
    localparam int DEF_CYC_INIT2   = 5000;
    localparam int DEF_CNT_W       = 20;

    // Clear display / return home commands need the long execution wait
    function automatic logic is_slow_cmd(input logic [7:0] b, input logic rs);
        return (rs == 1'b0) && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

    // Power-on wake-up nibbles: 3, 3, 3 then 2 to enter 4-bit mode
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd3:    nib = 4'h2;
            default: nib = 4'h3;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Drives one LCD nibble transfer: SETUP (E=0), PULSE (E=1), HOLD (E=0).
// Phase lengths come from the shared down-counter owned by the parent;
// the parent reloads it on every phase entry and this block advances
// whenever the counter reports zero.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   start          - begin a transfer on this edge (latches nibble/rs)
//   nibble, rs     - value to present on DB[7:4] and RS
//   cnt_zero       - shared delay counter has expired
//   done           - HOLD phase ends on this edge
//   e, data, rs_out- registered LCD E, DB[7:4] and RS
//   phase          - current strobe phase
module lcd_nibble_strobe
    import lcd_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    nibble,
    input  logic          rs,
    input  logic          cnt_zero,
    output logic          done,
    output logic          e,
    output logic [3:0]    data,
    output logic          rs_out,
    output strobe_phase_e phase
);

    strobe_phase_e phase_r;
    strobe_phase_e phase_nxt_s;
    logic          e_r;
    logic [3:0]    data_r;
    logic          rs_r;
    logic          done_s;

    // Phase sequencing; a start always wins and restarts at SETUP
    always_comb begin
        phase_nxt_s = phase_r;
        done_s      = (phase_r == PH_HOLD) && cnt_zero;
        if (start) begin
            phase_nxt_s = PH_SETUP;
        end else begin
            case (phase_r)
                PH_SETUP: phase_nxt_s = cnt_zero ? PH_PULSE : PH_SETUP;
                PH_PULSE: phase_nxt_s = cnt_zero ? PH_HOLD  : PH_PULSE;
                PH_HOLD:  phase_nxt_s = cnt_zero ? PH_OFF   : PH_HOLD;
                PH_OFF:   phase_nxt_s = PH_OFF;
                default:  phase_nxt_s = PH_OFF;
            endcase
        end
    end

    // Phase and pin registers; data/RS held for the whole nibble, then cleared
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= PH_OFF;
            e_r     <= 1'b0;
            data_r  <= 4'h0;
            rs_r    <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
            e_r     <= (phase_nxt_s == PH_PULSE);
            if (start) begin
                data_r <= nibble;
                rs_r   <= rs;
            end else if (done_s) begin
                data_r <= 4'h0;
                rs_r   <= 1'b0;
            end else begin
                data_r <= data_r;
                rs_r   <= rs_r;
            end
        end
    end

    assign done   = done_s;
    assign e      = e_r;
    assign data   = data_r;
    assign rs_out = rs_r;
    assign phase  = phase_r;

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes bytes to an HD44780-compatible LCD over a 4-bit bus, high nibble
// first, with optional power-on initialisation. All delays use a single
// CNT_W-bit down-counter loaded with N-1 on phase entry.
// Ports:
//   clk                     - clock, rising edge
//   iLCD_reset              - synchronous active-low reset
//   iLCD_data, iLCD_RS      - byte and register select to write
//   iLCD_writeEN            - write request, taken only while ready
//   oLCD_response           - ready (high only in IDLE)
//   oLCD_Data               - LCD DB[7:4]
//   oLCD_Enabled            - LCD E
//   oLCD_RegisterSelect     - LCD RS
//   oLCD_ReadWrite          - LCD R/W, tied to write
//   oLCD_StrataFlashControl - keeps the shared flash disabled
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int CYC_SETUP   = DEF_CYC_SETUP,
    parameter int CYC_EN      = DEF_CYC_EN,
    parameter int CYC_HOLD    = DEF_CYC_HOLD,
    parameter int CYC_NIB_GAP = DEF_CYC_NIB_GAP,
    parameter int CYC_CMD_GAP = DEF_CYC_CMD_GAP,
    parameter int CYC_CLR_GAP = DEF_CYC_CLR_GAP,
    parameter int CYC_PWRUP   = DEF_CYC_PWRUP,
    parameter int CYC_INIT1   = DEF_CYC_INIT1,
    parameter int CYC_INIT2   = DEF_CYC_INIT2,
    parameter int INIT_EN     = 1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       iLCD_reset,
    input  logic [7:0] iLCD_data,
    input  logic       iLCD_RS,
    input  logic       iLCD_writeEN,
    output logic       oLCD_response,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CYC_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(CYC_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CYC_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_NIB   = CNT_W'(CYC_NIB_GAP - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CYC_CMD_GAP - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CYC_CLR_GAP - 1);
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(CYC_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_INIT1 = CNT_W'(CYC_INIT1 - 1);
    localparam logic [CNT_W-1:0] LD_INIT2 = CNT_W'(CYC_INIT2 - 1);
    localparam lcd_state_e       RST_STATE = (INIT_EN != 0) ? ST_PWRUP : ST_IDLE;
    localparam logic             RST_READY = (INIT_EN != 0) ? 1'b0 : 1'b1;

    lcd_state_e       state_r;
    lcd_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_dec_s;
    logic             cnt_zero_s;
    logic [7:0]       byte_r;
    logic             rs_r;
    logic             latch_s;
    logic [1:0]       init_idx_r;
    logic [1:0]       idx_nxt_s;
    logic             ready_r;
    logic             start_s;
    logic [3:0]       nib_s;
    logic             nib_rs_s;
    logic             strobe_done_s;
    logic             strobe_e_s;
    logic [3:0]       strobe_data_s;
    logic             strobe_rs_s;
    strobe_phase_e    strobe_phase_s;

    // Gap that follows init nibble idx (0..3)
    function automatic logic [CNT_W-1:0] init_gap_ld(input logic [1:0] idx);
        logic [CNT_W-1:0] ld;
        case (idx)
            2'd0:    ld = LD_INIT1;
            2'd1:    ld = LD_INIT2;
            default: ld = LD_CMD;
        endcase
        return ld;
    endfunction

    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
    assign cnt_dec_s  = cnt_zero_s ? cnt_r : (cnt_r - CNT_ONE);

    // Next-state, counter reload and strobe launch decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_dec_s;
        start_s     = 1'b0;
        nib_s       = 4'h0;
        nib_rs_s    = 1'b0;
        latch_s     = 1'b0;
        idx_nxt_s   = init_idx_r;
        case (state_r)
            ST_PWRUP: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_INIT_NIB;
                    start_s     = 1'b1;
                    nib_s       = init_nibble(init_idx_r);
                    cnt_nxt_s   = LD_SETUP;
                end else begin
                    state_nxt_s = ST_PWRUP;
                end
            end
            ST_INIT_NIB: begin
                // Init nibbles are a single state; the strobe phase picks the reload
                case (strobe_phase_s)
                    PH_SETUP: cnt_nxt_s = cnt_zero_s ? LD_EN : cnt_dec_s;
                    PH_PULSE: cnt_nxt_s = cnt_zero_s ? LD_HOLD : cnt_dec_s;
                    PH_HOLD: begin
                        if (strobe_done_s) begin
                            state_nxt_s = ST_INIT_GAP;
                            cnt_nxt_s   = init_gap_ld(init_idx_r);
                        end else begin
                            state_nxt_s = ST_INIT_NIB;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_PWRUP;
                        cnt_nxt_s   = LD_PWRUP;
                    end
                endcase
            end
            ST_INIT_GAP: begin
                if (!cnt_zero_s) begin
                    state_nxt_s = ST_INIT_GAP;
                end else if (init_idx_r == 2'd3) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT_NIB;
                    idx_nxt_s   = init_idx_r + 2'd1;
                    start_s     = 1'b1;
                    nib_s       = init_nibble(init_idx_r + 2'd1);
                    cnt_nxt_s   = LD_SETUP;
                end
            end
            ST_IDLE: begin
                if (iLCD_writeEN && ready_r) begin
                    state_nxt_s = ST_HI_SETUP;
                    latch_s     = 1'b1;
                    start_s     = 1'b1;
                    nib_s       = iLCD_data[7:4];
                    nib_rs_s    = iLCD_RS;
                    cnt_nxt_s   = LD_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HI_SETUP: begin
                state_nxt_s = cnt_zero_s ? ST_HI_EN : ST_HI_SETUP;
                cnt_nxt_s   = cnt_zero_s ? LD_EN : cnt_dec_s;
            end
            ST_HI_EN: begin
                state_nxt_s = cnt_zero_s ? ST_HI_HOLD : ST_HI_EN;
                cnt_nxt_s   = cnt_zero_s ? LD_HOLD : cnt_dec_s;
            end
            ST_HI_HOLD: begin
                state_nxt_s = strobe_done_s ? ST_NIB_GAP : ST_HI_HOLD;
                cnt_nxt_s   = strobe_done_s ? LD_NIB : cnt_dec_s;
            end
            ST_NIB_GAP: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_LO_SETUP;
                    start_s     = 1'b1;
                    nib_s       = byte_r[3:0];
                    nib_rs_s    = rs_r;
                    cnt_nxt_s   = LD_SETUP;
                end else begin
                    state_nxt_s = ST_NIB_GAP;
                end
            end
            ST_LO_SETUP: begin
                state_nxt_s = cnt_zero_s ? ST_LO_EN : ST_LO_SETUP;
                cnt_nxt_s   = cnt_zero_s ? LD_EN : cnt_dec_s;
            end
            ST_LO_EN: begin
                state_nxt_s = cnt_zero_s ? ST_LO_HOLD : ST_LO_EN;
                cnt_nxt_s   = cnt_zero_s ? LD_HOLD : cnt_dec_s;
            end
            ST_LO_HOLD: begin
                if (strobe_done_s) begin
                    state_nxt_s = ST_BYTE_GAP;
                    cnt_nxt_s   = is_slow_cmd(byte_r, rs_r) ? LD_CLR : LD_CMD;
                end else begin
                    state_nxt_s = ST_LO_HOLD;
                end
            end
            ST_BYTE_GAP: begin
                state_nxt_s = cnt_zero_s ? ST_IDLE : ST_BYTE_GAP;
            end
            default: begin
                state_nxt_s = RST_STATE;
                cnt_nxt_s   = LD_PWRUP;
            end
        endcase
    end

    // Sequencer registers; ready is registered from the next state
    always_ff @(posedge clk) begin
        if (!iLCD_reset) begin
            state_r    <= RST_STATE;
            cnt_r      <= LD_PWRUP;
            byte_r     <= 8'h00;
            rs_r       <= 1'b0;
            init_idx_r <= 2'd0;
            ready_r    <= RST_READY;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            init_idx_r <= idx_nxt_s;
            ready_r    <= (state_nxt_s == ST_IDLE);
            if (latch_s) begin
                byte_r <= iLCD_data;
                rs_r   <= iLCD_RS;
            end else begin
                byte_r <= byte_r;
                rs_r   <= rs_r;
            end
        end
    end

    lcd_nibble_strobe u_strobe (
        .clk      (clk),
        .rst_n    (iLCD_reset),
        .start    (start_s),
        .nibble   (nib_s),
        .rs       (nib_rs_s),
        .cnt_zero (cnt_zero_s),
        .done     (strobe_done_s),
        .e        (strobe_e_s),
        .data     (strobe_data_s),
        .rs_out   (strobe_rs_s),
        .phase    (strobe_phase_s)
    );

    assign oLCD_response           = ready_r;
    assign oLCD_Enabled            = strobe_e_s;
    assign oLCD_Data               = strobe_data_s;
    assign oLCD_RegisterSelect     = strobe_rs_s;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: expected nibbles (value, RS and
// E-rise cycle) are queued when stimulus is driven and popped by a monitor
// on every E rising edge.
module tb_lcd_byte_writer;

    localparam int S    = 2;
    localparam int EN   = 3;
    localparam int H    = 1;
    localparam int NG   = 4;
    localparam int CMD  = 8;
    localparam int CLR  = 20;
    localparam int PWR  = 30;
    localparam int I1   = 12;
    localparam int I2   = 6;

    typedef struct {
        logic [3:0] nib;
        logic       rs;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       lcd_reset = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_rs = 1'b0;
    logic       wr_en = 1'b0;
    logic       resp;
    logic [3:0] data;
    logic       e;
    logic       rs;
    logic       rw;
    logic       flash;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lcd_byte_writer #(
        .CYC_SETUP(S), .CYC_EN(EN), .CYC_HOLD(H), .CYC_NIB_GAP(NG),
        .CYC_CMD_GAP(CMD), .CYC_CLR_GAP(CLR), .CYC_PWRUP(PWR),
        .CYC_INIT1(I1), .CYC_INIT2(I2), .INIT_EN(1), .CNT_W(20)
    ) dut (
        .clk                     (clk),
        .iLCD_reset              (lcd_reset),
        .iLCD_data               (wr_data),
        .iLCD_RS                 (wr_rs),
        .iLCD_writeEN            (wr_en),
        .oLCD_response           (resp),
        .oLCD_Data               (data),
        .oLCD_Enabled            (e),
        .oLCD_RegisterSelect     (rs),
        .oLCD_ReadWrite          (rw),
        .oLCD_StrataFlashControl (flash)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int busy_of(input logic [7:0] b, input logic r);
        int gap;
        gap = (!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? CLR : CMD;
        return 2 * (S + EN + H) + NG + gap;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic r, input int acc);
        sb.push_back('{nib: b[7:4], rs: r, cyc: acc + S});
        sb.push_back('{nib: b[3:0], rs: r, cyc: acc + S + EN + H + NG + S});
    endtask

    task automatic wait_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Releases reset after n low edges, queues the init nibbles, waits for ready
    task automatic reset_and_init(input int n);
        int   rel;
        int   t;
        int   at;
        int   gaps[4];
        logic [3:0] nibs[4];
        gaps = '{I1, I2, CMD, CMD};
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        lcd_reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        lcd_reset = 1'b1;
        rel = cyc;
        t = rel + PWR + S;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{nib: nibs[i], rs: 1'b0, cyc: t});
            if (i < 3) t = t + EN + H + gaps[i] + S;
        end
        wait_ready(400, at);
        if (at >= 0) check("init_ready_cycle", 32'(at), 32'(t + EN + H + CMD));
    endtask

    task automatic write_byte(input logic [7:0] b, input logic r);
        int at;
        int acc;
        wait_ready(200, at);
        wr_data = b;
        wr_rs   = r;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        wr_en = 1'b0;
        push_byte(b, r, acc);
        @(negedge clk);
        check("busy_after_accept", 32'(resp), 32'd0);
        wait_ready(200, at);
        if (at >= 0) check("busy_cycles", 32'(at - acc), 32'(busy_of(b, r)));
    endtask

    // Monitor: constant pins, idle pin values, scoreboard pop on E rise, E width
    initial begin : monitor
        logic e_prev;
        int   width;
        exp_t cur;
        exp_t ex;
        e_prev = 1'b0;
        width  = 0;
        cur    = '{nib: 4'h0, rs: 1'b0, cyc: 0};
        forever begin
            @(negedge clk);
            check("rw_const", 32'(rw), 32'd0);
            check("flash_const", 32'(flash), 32'd1);
            if (resp === 1'b1) begin
                check("idle_data", 32'(data), 32'd0);
                check("idle_rs", 32'(rs), 32'd0);
            end
            if (e === 1'b1 && e_prev === 1'b0) begin
                width = 1;
                if (sb.size() == 0) begin
                    check("stray_pulse", 32'({rs, data}), 32'hFFFF);
                    cur = '{nib: data, rs: rs, cyc: cyc};
                end else begin
                    ex  = sb.pop_front();
                    cur = ex;
                    check("nib_data", 32'(data), 32'(ex.nib));
                    check("nib_rs", 32'(rs), 32'(ex.rs));
                    check("rise_cycle", 32'(cyc), 32'(ex.cyc));
                end
            end else if (e === 1'b1) begin
                width++;
                check("data_stable", 32'({rs, data}), 32'({cur.rs, cur.nib}));
            end else if (e_prev === 1'b1 && lcd_reset === 1'b1) begin
                check("e_width", 32'(width), 32'(EN));
            end
            e_prev = e;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int at;
        int acc;
        logic [7:0] bytes[7];
        logic       rss[7];
        bytes = '{8'h48, 8'h01, 8'h28, 8'h02, 8'h03, 8'h04, 8'h00};
        rss   = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e", 32'(e), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_rs", 32'(rs), 32'd0);
        check("rst_ready", 32'(resp), 32'd0);

        // Power-on init
        reset_and_init(1);

        // Data bytes and commands, including the slow-command boundary
        for (int i = 0; i < 7; i++) write_byte(bytes[i], rss[i]);

        // writeEN held high across the busy window with changing data
        wait_ready(200, at);
        wr_data = 8'h55;
        wr_rs   = 1'b1;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        push_byte(8'h55, 1'b1, acc);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                at = cyc;
                break;
            end
            wr_data = 8'($urandom);
            wr_rs   = 1'($urandom);
        end
        if (at < 0) check("held_ready_timeout", 32'd0, 32'd1);
        else check("held_busy_cycles", 32'(at - acc), 32'(busy_of(8'h55, 1'b1)));
        // Still requesting: the next edge accepts the following byte
        wr_data = 8'hA7;
        wr_rs   = 1'b0;
        @(posedge clk);
        #1;
        acc   = cyc;
        wr_en = 1'b0;
        push_byte(8'hA7, 1'b0, acc);
        @(negedge clk);
        check("b2b_accept", 32'(resp), 32'd0);
        wait_ready(200, at);
        if (at >= 0) check("b2b_busy_cycles", 32'(at - acc), 32'(busy_of(8'hA7, 1'b0)));

        // Reset while E is high on the high nibble
        wait_ready(200, at);
        wr_data = 8'h3C;
        wr_rs   = 1'b1;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        wr_en = 1'b0;
        sb.push_back('{nib: 4'h3, rs: 1'b1, cyc: acc + S});
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (e === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("hi_pulse_timeout", 32'd0, 32'd1);
        lcd_reset = 1'b0;
        @(negedge clk);
        check("midrst_e", 32'(e), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_rs", 32'(rs), 32'd0);
        check("midrst_ready", 32'(resp), 32'd0);
        reset_and_init(1);

        // One more byte after recovery, then drain
        write_byte(8'h41, 1'b1);
        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
